// File: rtl/mmio_csr_pkg.sv
// Shared definitions for the MMIO CSR responder.
// Holds the register indices (word-pair offset from START_ADDR), the CTRL and STATUS bit positions,
// and the start/done FSM state encoding.
package mmio_csr_pkg;

  // Register indices, i.e. (addr - START_ADDR) / 2
  localparam int REG_ID       = 0;
  localparam int REG_CTRL     = 1;
  localparam int REG_STATUS   = 2;
  localparam int REG_CYCLES   = 3;
  localparam int REG_SCRATCH  = 4;
  localparam int REG_CFG_BASE = 5;

  // CTRL bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  // STATUS bit positions
  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/go_done_tracker.sv
// Start/done sequencer: emits a one-cycle go pulse, holds busy until done arrives,
// measures busy cycles (saturating), and keeps done/error sticky flags.
// Ports: start_req_i/clear_req_i (decoded CTRL write), done_i (datapath), go_o, busy_o,
// cycles_o, done_sticky_o, err_sticky_o.
module go_done_tracker
  import mmio_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_req_i,
  input  logic        clear_req_i,
  input  logic        done_i,
  output logic        go_o,
  output logic        busy_o,
  output logic [63:0] cycles_o,
  output logic        done_sticky_o,
  output logic        err_sticky_o
);

  state_e      state_q, state_d;
  logic        go_q, go_d;
  logic [63:0] cycles_q, cycles_d;
  logic        done_stk_q, done_stk_d;
  logic        err_stk_q, err_stk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      go_q       <= 1'b0;
      cycles_q   <= '0;
      done_stk_q <= 1'b0;
      err_stk_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      cycles_q   <= cycles_d;
      done_stk_q <= done_stk_d;
      err_stk_q  <= err_stk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    go_d       = 1'b0;
    cycles_d   = cycles_q;
    done_stk_d = done_stk_q;
    err_stk_d  = err_stk_q;

    // Clear is applied before the start/done rules, so CTRL=3 clears then starts.
    if (clear_req_i) begin
      done_stk_d = 1'b0;
      err_stk_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // done while idle is ignored
        if (start_req_i) begin
          state_d    = ST_BUSY;
          go_d       = 1'b1;
          cycles_d   = '0;
          done_stk_d = 1'b0;
        end
      end
      ST_BUSY: begin
        // Counts every busy cycle, including the one in which done arrives.
        if (cycles_q != '1) cycles_d = cycles_q + 64'd1;
        // A start while busy is an error and is never queued, even if done lands in the same cycle.
        if (start_req_i) err_stk_d = 1'b1;
        if (done_i) begin
          state_d    = ST_IDLE;
          done_stk_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign go_o          = go_q;
  assign busy_o        = (state_q == ST_BUSY);
  assign cycles_o      = cycles_q;
  assign done_sticky_o = done_stk_q;
  assign err_sticky_o  = err_stk_q;

endmodule

// File: rtl/mmio_csr_responder.sv
// AFU-side MMIO responder: decodes reads/writes into a 64-bit register map (ID, CTRL, STATUS,
// CYCLES, SCRATCH, CFG[]) and returns read data registered one cycle after mmio_rd_en.
// Ports: mmio_rd_*/mmio_wr_* (HAL MMIO), go/busy/done (datapath handshake), cfg (packed config).
module mmio_csr_responder
  import mmio_csr_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR   = 16'h0050,
  parameter int                    NUM_CFG_REGS = 4,
  parameter logic [DATA_WIDTH-1:0] AFU_ID       = 64'h0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mmio_rd_en,
  input  logic [ADDR_WIDTH-1:0]              mmio_rd_addr,
  input  logic                               mmio_wr_en,
  input  logic [ADDR_WIDTH-1:0]              mmio_wr_addr,
  input  logic [DATA_WIDTH-1:0]              mmio_wr_data,
  output logic [DATA_WIDTH-1:0]              mmio_rd_data,
  output logic                               go,
  output logic                               busy,
  input  logic                               done,
  output logic [NUM_CFG_REGS*DATA_WIDTH-1:0] cfg
);

  localparam int NUM_REGS = REG_CFG_BASE + NUM_CFG_REGS;

  // Offsets wrap modulo 2^ADDR_WIDTH; each 64-bit register spans two 32-bit words.
  logic [ADDR_WIDTH-1:0] rd_off, wr_off;
  int                    rd_idx, wr_idx;
  logic                  rd_hit, wr_hit;

  assign rd_off = mmio_rd_addr - START_ADDR;
  assign wr_off = mmio_wr_addr - START_ADDR;
  assign rd_idx = int'(rd_off[ADDR_WIDTH-1:1]);
  assign wr_idx = int'(wr_off[ADDR_WIDTH-1:1]);
  assign rd_hit = !rd_off[0] && (rd_idx < NUM_REGS);
  assign wr_hit = !wr_off[0] && (wr_idx < NUM_REGS);

  logic [DATA_WIDTH-1:0]                     scratch_q;
  logic [NUM_CFG_REGS-1:0][DATA_WIDTH-1:0]   cfg_q;
  logic [DATA_WIDTH-1:0]                     rd_data_q, rd_data_d;

  logic        start_req, clear_req;
  logic [63:0] cycles;
  logic        done_sticky, err_sticky;

  assign start_req = mmio_wr_en && wr_hit && (wr_idx == REG_CTRL) && mmio_wr_data[CTRL_START_BIT];
  assign clear_req = mmio_wr_en && wr_hit && (wr_idx == REG_CTRL) && mmio_wr_data[CTRL_CLEAR_BIT];

  go_done_tracker u_tracker (
    .clk           (clk),
    .rst           (rst),
    .start_req_i   (start_req),
    .clear_req_i   (clear_req),
    .done_i        (done),
    .go_o          (go),
    .busy_o        (busy),
    .cycles_o      (cycles),
    .done_sticky_o (done_sticky),
    .err_sticky_o  (err_sticky)
  );

  // Read mux works off current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_data_d = '0;
    if (rd_hit) begin
      case (rd_idx)
        REG_ID:      rd_data_d = AFU_ID;
        REG_STATUS: begin
          rd_data_d[STAT_DONE_BIT] = done_sticky;
          rd_data_d[STAT_BUSY_BIT] = busy;
          rd_data_d[STAT_ERR_BIT]  = err_sticky;
        end
        REG_CYCLES:  rd_data_d = cycles;
        REG_SCRATCH: rd_data_d = scratch_q;
        default: begin
          // CTRL is write-only and falls through to zero here.
          for (int i = 0; i < NUM_CFG_REGS; i++) begin
            if (rd_idx == REG_CFG_BASE + i) rd_data_d = cfg_q[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      scratch_q <= '0;
      cfg_q     <= '0;
    end else begin
      if (mmio_rd_en) rd_data_q <= rd_data_d;
      if (mmio_wr_en && wr_hit) begin
        if (wr_idx == REG_SCRATCH) scratch_q <= mmio_wr_data;
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
          if (wr_idx == REG_CFG_BASE + i) cfg_q[i] <= mmio_wr_data;
        end
      end
    end
  end

  assign mmio_rd_data = rd_data_q;
  assign cfg          = cfg_q;

endmodule

// File: tb/tb_mmio_csr_responder.sv
module tb_mmio_csr_responder;
  localparam logic [15:0] BASE   = 16'h0050;
  localparam logic [63:0] ID_VAL = 64'hC0FFEE;
  localparam int          NCFG   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mmio_rd_en = 1'b0;
  logic [15:0]     mmio_rd_addr = '0;
  logic            mmio_wr_en = 1'b0;
  logic [15:0]     mmio_wr_addr = '0;
  logic [63:0]     mmio_wr_data = '0;
  logic [63:0]     mmio_rd_data;
  logic            go, busy;
  logic            done = 1'b0;
  logic [NCFG*64-1:0] cfg;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic        pend = 1'b0;

  mmio_csr_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(16), .START_ADDR(BASE),
    .NUM_CFG_REGS(NCFG), .AFU_ID(ID_VAL)
  ) dut (
    .clk(clk), .rst(rst),
    .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr),
    .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data),
    .go(go), .busy(busy), .done(done), .cfg(cfg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A read accepted at a posedge must show its data by the following negedge.
  always @(posedge clk) pend <= mmio_rd_en && !rst;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", mmio_rd_data, 64'hX);
      end else begin
        check(tag_q.pop_front(), mmio_rd_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [15:0] ra(input int idx);
    return BASE + 16'(2 * idx);
  endfunction

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_en = 1'b1; mmio_wr_addr = a; mmio_wr_data = d;
    @(negedge clk);
    mmio_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [63:0] exp, input string tag);
    mmio_rd_en = 1'b1; mmio_rd_addr = a;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(negedge clk);
    mmio_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, ngo;
    logic [63:0] slice;

    repeat (3) @(negedge clk);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", mmio_rd_data, 0);
    check("rst_cfg", cfg[63:0] | cfg[127:64] | cfg[191:128] | cfg[255:192], 0);
    rst = 1'b0;
    @(negedge clk);

    // Every register after reset
    for (int k = 0; k < 5 + NCFG; k++)
      rd(ra(k), (k == 0) ? ID_VAL : 64'h0, $sformatf("reset_reg%0d", k));

    // SCRATCH / CFG writes and odd-address miss
    wr(ra(4), 64'hDEADBEEF_01234567);
    wr(16'h005E, 64'd5);
    rd(ra(4), 64'hDEADBEEF_01234567, "scratch_rb");
    rd(16'h005E, 64'd5, "cfg2_rb");
    slice = cfg[191:128];
    check("cfg2_port", slice, 64'd5);
    wr(16'h0051, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(16'h0051, 64'h0, "odd_addr_rd");
    rd(ra(4), 64'hDEADBEEF_01234567, "scratch_after_odd");
    slice = cfg[63:0] | cfg[127:64] | cfg[255:192];
    check("cfg_others_port", slice, 0);
    check("odd_no_busy", busy, 0);
    // Read and write of SCRATCH in the same cycle returns the old value
    mmio_wr_en = 1'b1; mmio_wr_addr = ra(4); mmio_wr_data = 64'h1111;
    mmio_rd_en = 1'b1; mmio_rd_addr = ra(4);
    exp_q.push_back(64'hDEADBEEF_01234567); tag_q.push_back("rw_same_cycle");
    @(negedge clk);
    mmio_wr_en = 1'b0; mmio_rd_en = 1'b0;
    rd(ra(4), 64'h1111, "scratch_new");
    rd(16'hFFF0, 64'h0, "far_miss");

    // Start, done on the 10th busy cycle
    wr(ra(1), 64'd1);
    nbusy = 0; ngo = 0;
    for (int j = 0; j < 10; j++) begin
      if (busy) nbusy++;
      if (go) ngo++;
      if (j == 9) done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    check("run1_busy_cycles", 64'(nbusy), 64'd10);
    check("run1_go_cycles", 64'(ngo), 64'd1);
    check("run1_busy_end", busy, 0);
    rd(ra(2), 64'd1, "run1_status");
    rd(ra(3), 64'd10, "run1_cycles");

    // Start while busy
    wr(ra(1), 64'd1);
    check("run2_go", go, 1);
    wr(ra(1), 64'd1);
    check("run2_no_second_go", go, 0);
    rd(ra(2), 64'd6, "run2_status_busy_err");
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    rd(ra(2), 64'd5, "run2_status_done_err");
    rd(ra(3), 64'd3, "run2_cycles");
    wr(ra(1), 64'd2);
    rd(ra(2), 64'd0, "clear_status");
    rd(ra(3), 64'd3, "clear_cycles_kept");

    // done while idle is ignored
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    rd(ra(2), 64'd0, "idle_done_status");

    // done coinciding with a start while busy
    wr(ra(1), 64'd1);
    done = 1'b1;
    wr(ra(1), 64'd1);
    done = 1'b0;
    check("coinc_go", go, 0);
    check("coinc_busy", busy, 0);
    rd(ra(2), 64'd5, "coinc_status");
    rd(ra(3), 64'd1, "coinc_cycles");

    // Clear + start together: stickies cleared, new run begins
    wr(ra(1), 64'd3);
    check("cs_go", go, 1);
    rd(ra(2), 64'd2, "cs_status");

    // Reset mid-busy with a read in flight
    mmio_rd_en = 1'b1; mmio_rd_addr = ra(0);
    rst = 1'b1;
    #1;
    check("arst_go", go, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_data", mmio_rd_data, 0);
    @(negedge clk);
    check("arst_rd_dropped", mmio_rd_data, 0);
    mmio_rd_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5 + NCFG; k++)
      rd(ra(k), (k == 0) ? ID_VAL : 64'h0, $sformatf("post_rst_reg%0d", k));
    check("post_rst_cfg", cfg[63:0] | cfg[127:64] | cfg[191:128] | cfg[255:192], 0);

    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
